// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS instruction-fetch stage.
// Owns the PC, requests instructions from imem, hands {instr, instr_pc} to
// decode and accepts branch/jump redirects from later stages.
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky
// align_fault and halt fetch; without it, targets are word-aligned by masking.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [31:0]        pc,
  input  logic [31:0]        pc_plus4,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [COUNT_W-1:0] fetch_count
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic               align_fault
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic                pend_q, pend_d;
  logic [31:0]         pend_pc_q, pend_pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                req_q;

  logic                take_c;
  logic                bad_c;
  logic                halted_c;
  logic [31:0]         tgt_c;

`ifdef PC_ALIGN_CHECK_EN
  logic                fault_q, fault_d;

  // Misaligned targets fault instead of loading; a faulted unit ignores redirects
  always_comb begin
    tgt_c    = redirect_pc;
    halted_c = fault_q;
    bad_c    = redirect & (|redirect_pc[1:0]) & ~fault_q;
    take_c   = redirect & ~(|redirect_pc[1:0]) & ~fault_q;
  end

  assign align_fault = fault_q;
`else
  // Targets are forced onto a word boundary
  always_comb begin
    tgt_c    = redirect_pc & 32'hFFFF_FFFC;
    halted_c = 1'b0;
    bad_c    = 1'b0;
    take_c   = redirect;
  end
`endif

  // Next-state and datapath update for the IDLE/REQ/VALID fetch FSM
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    count_d    = count_q;
`ifdef PC_ALIGN_CHECK_EN
    fault_d    = fault_q;
`endif

    if (bad_c) begin
      state_d = IDLE;
      valid_d = 1'b0;
      pend_d  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      fault_d = 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (take_c) begin
            pc_d    = tgt_c;
            valid_d = 1'b0;
            state_d = REQ;
          end else if (!halted_c) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (imem_ready) begin
            if (take_c) begin
              pc_d   = tgt_c;
              pend_d = 1'b0;
            end else if (pend_q) begin
              pc_d   = pend_pc_q;
              pend_d = 1'b0;
            end else begin
              instr_d    = imem_rdata;
              instr_pc_d = pc_q;
              valid_d    = 1'b1;
              pc_d       = pc_plus4;
              state_d    = VALID;
            end
          end else if (take_c) begin
            // Address must stay stable while the request is outstanding
            pend_d    = 1'b1;
            pend_pc_d = tgt_c;
          end
        end
        VALID: begin
          if (take_c) begin
            pc_d    = tgt_c;
            valid_d = 1'b0;
            state_d = REQ;
          end else if (id_ready) begin
            valid_d = 1'b0;
            count_d = count_q + COUNT_W'(1);
            state_d = REQ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      req_q      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      req_q      <= (state_d == REQ);
`ifdef PC_ALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit.
// Expected {instr, instr_pc} pairs are queued by the stimulus; a negedge
// monitor pops and compares on every decode handshake.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc, pc_plus4, imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  logic        imem_req, imem_ready, instr_valid, id_ready, redirect;
  logic [15:0] fetch_count;

  logic [31:0] pc1, pc1_plus4, imem_addr1, imem_rdata1, instr1, instr_pc1;
  logic        imem_req1, instr_valid1;
  logic [15:0] fetch_count1;

`ifdef PC_ALIGN_CHECK_EN
  logic        align_fault, align_fault1;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Environment: adder and instruction memory contents
  assign pc_plus4    = pc + 32'd4;
  assign imem_rdata  = mem_word(imem_addr);
  assign pc1_plus4   = pc1 + 32'd4;
  assign imem_rdata1 = mem_word(imem_addr1);

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pc_plus4(pc_plus4),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .id_ready(id_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .fetch_count(fetch_count)
`ifdef PC_ALIGN_CHECK_EN
    , .align_fault(align_fault)
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .COUNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .pc(pc1), .pc_plus4(pc1_plus4),
    .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ready(1'b1),
    .imem_rdata(imem_rdata1), .instr_valid(instr_valid1), .instr(instr1),
    .instr_pc(instr_pc1), .id_ready(1'b1), .redirect(1'b0),
    .redirect_pc(32'h0), .fetch_count(fetch_count1)
`ifdef PC_ALIGN_CHECK_EN
    , .align_fault(align_fault1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    sb.push_back({mem_word(a), a});
  endtask

  // Monitor: compare every decode handshake against the scoreboard
  always @(negedge clk) begin
    if (reset_n === 1'b1 && instr_valid && id_ready && !redirect) begin
      if (sb.size() == 0) begin
        chk("unexpected_instr", {instr, instr_pc}, 64'h0);
      end else begin
        chk("instr_pair", {instr, instr_pc}, sb.pop_front());
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    imem_ready  = 1'b1;
    id_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_req", 64'(imem_req), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_count", 64'(fetch_count), 64'h0);
    chk("rst_pc1", 64'(pc1), 64'hFFFF_FFFC);

    // Sequential fetch 0,4,8,C with always-ready memory and decode
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    reset_n = 1'b1;
    step();
    step();
    chk("wrap_instr_pc1", 64'(instr_pc1), 64'hFFFF_FFFC);
    chk("wrap_valid1", 64'(instr_valid1), 64'h1);
    chk("wrap_addr1", 64'(imem_addr1), 64'h0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (fetch_count == 16'd4) begin
          hit = 1'b1;
          break;
        end
      end
      imem_ready = 1'b0;
      id_ready   = 1'b0;
      chk("count4_reached", 64'(hit), 64'h1);
    end
    chk("count4", 64'(fetch_count), 64'h4);
    chk("seq_addr", 64'(imem_addr), 64'h10);
    chk("seq_req", 64'(imem_req), 64'h1);

    // Decode stall: output held stable, no new request
    push(32'h10);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 64'(instr_valid), 64'h1);
      chk("stall_pair", {instr, instr_pc}, {mem_word(32'h10), 32'h10});
      chk("stall_req", 64'(imem_req), 64'h0);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("stall_count", 64'(fetch_count), 64'h5);

    // Redirect while request outstanding: deferred until memory responds
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("pend_addr_a", 64'(imem_addr), 64'h14);
    chk("pend_req", 64'(imem_req), 64'h1);
    step();
    chk("pend_addr_b", 64'(imem_addr), 64'h14);
    imem_ready = 1'b1;
    step();
    chk("pend_taken", 64'(imem_addr), 64'h100);
    chk("pend_dropped", 64'(instr_valid), 64'h0);
    push(32'h100);
    id_ready = 1'b1;
    step();
    step();
    imem_ready = 1'b0;
    id_ready   = 1'b0;
    chk("redir_count", 64'(fetch_count), 64'h6);

    // Redirect in VALID drops the instruction even with id_ready
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    chk("v_instr_pc", 64'(instr_pc), 64'h104);
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    id_ready = 1'b0;
    chk("v_drop_valid", 64'(instr_valid), 64'h0);
    chk("v_drop_count", 64'(fetch_count), 64'h6);
    chk("v_drop_addr", 64'(imem_addr), 64'h200);

    // Reset wins over a same-cycle imem_ready
    reset_n    = 1'b0;
    imem_ready = 1'b1;
    step();
    chk("rst2_valid", 64'(instr_valid), 64'h0);
    chk("rst2_pc", 64'(pc), 64'h0);
    chk("rst2_count", 64'(fetch_count), 64'h0);
    chk("rst2_req", 64'(imem_req), 64'h0);

    // Misaligned redirect target
    reset_n     = 1'b1;
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("align_fault", 64'(align_fault), 64'h1);
    chk("align_req", 64'(imem_req), 64'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    imem_ready  = 1'b1;
    step();
    redirect = 1'b0;
    step();
    chk("align_sticky", 64'(align_fault), 64'h1);
    chk("align_halt_req", 64'(imem_req), 64'h0);
    chk("align_halt_pc", 64'(imem_addr), 64'h0);
    chk("align_no_valid", 64'(instr_valid), 64'h0);
    imem_ready = 1'b0;
`else
    chk("align_mask_addr", 64'(imem_addr), 64'h100);
    chk("align_mask_req", 64'(imem_req), 64'h1);
    push(32'h100);
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    step();
    step();
    imem_ready = 1'b0;
    id_ready   = 1'b0;
    chk("align_mask_count", 64'(fetch_count), 64'h1);
`endif

    step();
    step();
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
